mastermind_grader: RTL and testbench

- Scores one Mastermind guess against the stored master pattern.
- Returns the feedback counts: zones are exact position matches; znarlys are colour-only matches.
- Asserts `won`, or `lost` on the last round, so the game-control FSM can leave its Grading state.
- Sits on the other side of the controller's grade request: consumes `grade_it`/`f_clear` and produces the `won`/`lost` it waits on.

---
 rtl/mastermind_pkg.sv | 18 +
 rtl/mastermind_grader_color_finder.sv | 25 ++
 rtl/mastermind_grader.sv | 176 +++++++++++++++++
 tb/tb_mastermind_grader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared defaults, peg/pattern types and FSM state encoding for the Mastermind grader.
package mastermind_pkg;

    localparam int unsigned NUM_PEGS   = 4;
    localparam int unsigned COLOR_W    = 3;
    localparam int unsigned MAX_ROUNDS = 8;

    typedef logic [COLOR_W-1:0] color_t;
    typedef color_t [NUM_PEGS-1:0] pattern_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXACT,
        S_COLOR,
        S_REPORT
    } grader_state_t;

endpackage

// File: rtl/mastermind_grader_color_finder.sv
// Combinational priority search: lowest master peg of the target colour not yet consumed.
module color_finder #(
    parameter int unsigned NUM_PEGS = mastermind_pkg::NUM_PEGS,
    parameter int unsigned COLOR_W  = mastermind_pkg::COLOR_W,
    parameter int unsigned IDX_W    = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1
) (
    input  logic [COLOR_W-1:0]               target,
    input  logic [NUM_PEGS-1:0][COLOR_W-1:0] master,
    input  logic [NUM_PEGS-1:0]              mused,
    output logic                             found,
    output logic [IDX_W-1:0]                 idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned j = 0; j < NUM_PEGS; j++) begin
            if (!found && !mused[j] && (master[j] == target)) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mastermind_grader.sv
// Sequential Mastermind scorer: one exact-match pass, one colour-match pass, then a registered report.
module mastermind_grader #(
    parameter int unsigned NUM_PEGS   = mastermind_pkg::NUM_PEGS,
    parameter int unsigned COLOR_W    = mastermind_pkg::COLOR_W,
    parameter int unsigned MAX_ROUNDS = mastermind_pkg::MAX_ROUNDS
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               grade_it,
    input  logic                               clear,
    input  logic [NUM_PEGS*COLOR_W-1:0]        master_pattern,
    input  logic [NUM_PEGS*COLOR_W-1:0]        guess,
    input  logic [$clog2(MAX_ROUNDS+1)-1:0]    round_num,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(NUM_PEGS+1)-1:0]      zones,
    output logic [$clog2(NUM_PEGS+1)-1:0]      znarlys,
    output logic                               won,
    output logic                               lost
);
    import mastermind_pkg::*;

    localparam int unsigned IDX_W = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_PEGS + 1);
    localparam int unsigned RND_W = $clog2(MAX_ROUNDS + 1);

    grader_state_t                    state_q, state_d;
    logic [NUM_PEGS-1:0][COLOR_W-1:0] master_q, master_d;
    logic [NUM_PEGS-1:0][COLOR_W-1:0] guess_q, guess_d;
    logic [RND_W-1:0]                 round_q, round_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [NUM_PEGS-1:0]              gused_q, gused_d;
    logic [NUM_PEGS-1:0]              mused_q, mused_d;
    logic [CNT_W-1:0]                 zcnt_q, zcnt_d;
    logic [CNT_W-1:0]                 ncnt_q, ncnt_d;
    logic [CNT_W-1:0]                 zones_q, zones_d;
    logic [CNT_W-1:0]                 znarlys_q, znarlys_d;
    logic                             won_q, won_d;
    logic                             lost_q, lost_d;
    logic                             done_q, done_d;

    logic             cf_found;
    logic [IDX_W-1:0] cf_idx;
    logic             last_idx;

    color_finder #(
        .NUM_PEGS (NUM_PEGS),
        .COLOR_W  (COLOR_W),
        .IDX_W    (IDX_W)
    ) u_color_finder (
        .target (guess_q[idx_q]),
        .master (master_q),
        .mused  (mused_q),
        .found  (cf_found),
        .idx    (cf_idx)
    );

    assign last_idx = (idx_q == IDX_W'(NUM_PEGS - 1));

    always_comb begin
        state_d   = state_q;
        master_d  = master_q;
        guess_d   = guess_q;
        round_d   = round_q;
        idx_d     = idx_q;
        gused_d   = gused_q;
        mused_d   = mused_q;
        zcnt_d    = zcnt_q;
        ncnt_d    = ncnt_q;
        zones_d   = zones_q;
        znarlys_d = znarlys_q;
        won_d     = won_q;
        lost_d    = lost_q;
        done_d    = 1'b0;

        if (clear) begin
            state_d   = S_IDLE;
            zones_d   = '0;
            znarlys_d = '0;
            won_d     = 1'b0;
            lost_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (grade_it) begin
                        master_d = master_pattern;
                        guess_d  = guess;
                        round_d  = round_num;
                        idx_d    = '0;
                        gused_d  = '0;
                        mused_d  = '0;
                        zcnt_d   = '0;
                        ncnt_d   = '0;
                        state_d  = S_EXACT;
                    end
                end
                S_EXACT: begin
                    if (guess_q[idx_q] == master_q[idx_q]) begin
                        zcnt_d         = zcnt_q + 1'b1;
                        gused_d[idx_q] = 1'b1;
                        mused_d[idx_q] = 1'b1;
                    end
                    if (last_idx) begin
                        idx_d   = '0;
                        state_d = S_COLOR;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                S_COLOR: begin
                    // Exactly-matched guess pegs are skipped; their master peg is already consumed.
                    if (!gused_q[idx_q] && cf_found) begin
                        ncnt_d          = ncnt_q + 1'b1;
                        mused_d[cf_idx] = 1'b1;
                    end
                    if (last_idx) begin
                        state_d = S_REPORT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                S_REPORT: begin
                    zones_d   = zcnt_q;
                    znarlys_d = ncnt_q;
                    won_d     = (zcnt_q == CNT_W'(NUM_PEGS));
                    lost_d    = (zcnt_q != CNT_W'(NUM_PEGS)) && (round_q == RND_W'(MAX_ROUNDS));
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            master_q  <= '0;
            guess_q   <= '0;
            round_q   <= '0;
            idx_q     <= '0;
            gused_q   <= '0;
            mused_q   <= '0;
            zcnt_q    <= '0;
            ncnt_q    <= '0;
            zones_q   <= '0;
            znarlys_q <= '0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            master_q  <= master_d;
            guess_q   <= guess_d;
            round_q   <= round_d;
            idx_q     <= idx_d;
            gused_q   <= gused_d;
            mused_q   <= mused_d;
            zcnt_q    <= zcnt_d;
            ncnt_q    <= ncnt_d;
            zones_q   <= zones_d;
            znarlys_q <= znarlys_d;
            won_q     <= won_d;
            lost_q    <= lost_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign zones   = zones_q;
    assign znarlys = znarlys_q;
    assign won     = won_q;
    assign lost    = lost_q;

endmodule

// File: tb/tb_mastermind_grader.sv
// Scoreboard bench: stimulus pushes reference results, a negedge monitor checks each done pulse.
module tb_mastermind_grader;

    localparam int NP = 4;
    localparam int CW = 3;
    localparam int MR = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        grade_it = 1'b0;
    logic        clear = 1'b0;
    logic [11:0] master_pattern = '0;
    logic [11:0] guess = '0;
    logic [3:0]  round_num = '0;
    logic        busy, done, won, lost;
    logic [2:0]  zones, znarlys;

    mastermind_grader #(
        .NUM_PEGS   (NP),
        .COLOR_W    (CW),
        .MAX_ROUNDS (MR)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .grade_it       (grade_it),
        .clear          (clear),
        .master_pattern (master_pattern),
        .guess          (guess),
        .round_num      (round_num),
        .busy           (busy),
        .done           (done),
        .zones          (zones),
        .znarlys        (znarlys),
        .won            (won),
        .lost           (lost)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          z;
        int          n;
        int          w;
        int          l;
        int unsigned due;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
        return {3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // Mastermind rule: colour overlap is the per-colour minimum of counts; znarlys are overlap minus exact hits.
    function automatic exp_t model(input logic [11:0] m, input logic [11:0] g, input logic [3:0] r);
        exp_t e;
        int   cm[8];
        int   cg[8];
        int   z;
        int   common;
        logic [2:0] mc, gc;
        for (int k = 0; k < 8; k++) begin
            cm[k] = 0;
            cg[k] = 0;
        end
        z = 0;
        for (int i = 0; i < NP; i++) begin
            mc = m[i*CW +: CW];
            gc = g[i*CW +: CW];
            if (mc == gc) z++;
            cm[mc]++;
            cg[gc]++;
        end
        common = 0;
        for (int k = 0; k < 8; k++) common += (cm[k] < cg[k]) ? cm[k] : cg[k];
        e.z   = z;
        e.n   = common - z;
        e.w   = (z == NP) ? 1 : 0;
        e.l   = (z != NP && r == 4'(MR)) ? 1 : 0;
        e.due = 0;
        return e;
    endfunction

    always @(negedge clock) begin
        if (reset && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done=1 with no grade outstanding (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_cycle", int'(cyc), int'(e.due));
                chk("zones", int'(zones), e.z);
                chk("znarlys", int'(znarlys), e.n);
                chk("won", int'(won), e.w);
                chk("lost", int'(lost), e.l);
                chk("busy_in_done", int'(busy), 0);
            end
        end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
            checks++;
            errors++;
            $display("FAIL missing_done: no done by cycle %0d expected at %0d", cyc, sbq[0].due);
            void'(sbq.pop_front());
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_zones"}, int'(zones), 0);
        chk({tag, "_znarlys"}, int'(znarlys), 0);
        chk({tag, "_won"}, int'(won), 0);
        chk({tag, "_lost"}, int'(lost), 0);
    endtask

    // Called at a negedge; the request is sampled on the following posedge.
    task automatic issue(input logic [11:0] m, input logic [11:0] g, input logic [3:0] r,
                         input bit expect_done);
        exp_t e;
        master_pattern = m;
        guess          = g;
        round_num      = r;
        grade_it       = 1'b1;
        if (expect_done) begin
            e     = model(m, g, r);
            e.due = cyc + 10;
            sbq.push_back(e);
        end
        @(negedge clock);
        grade_it       = 1'b0;
        master_pattern = 12'($urandom);
        guess          = 12'($urandom);
        round_num      = 4'($urandom);
        chk("busy_after_req", int'(busy), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        wait_n(3);
        chk_zero("in_reset");
        reset = 1'b1;
        wait_n(1);
        chk_zero("after_reset");

        issue(pk(1,2,3,4), pk(1,2,3,4), 4'd3, 1'b1);
        wait_n(9);

        issue(pk(5,5,5,5), pk(5,1,1,5), 4'd2, 1'b0);
        wait_n(5);
        reset = 1'b0;
        #1;
        chk_zero("reset_mid_color");
        wait_n(1);
        reset = 1'b1;
        wait_n(1);

        issue(pk(1,2,3,4), pk(1,2,3,4), 4'd3, 1'b1); wait_n(9);
        issue(pk(1,1,2,2), pk(2,2,1,1), 4'd1, 1'b1); wait_n(9);
        issue(pk(1,2,3,4), pk(1,1,1,1), 4'd2, 1'b1); wait_n(9);
        issue(pk(1,1,2,3), pk(1,2,1,1), 4'd4, 1'b1); wait_n(9);
        issue(pk(7,6,5,4), pk(0,0,0,0), 4'd8, 1'b1); wait_n(9);
        issue(pk(7,6,5,4), pk(0,0,0,0), 4'd7, 1'b1); wait_n(9);

        issue(pk(1,1,2,3), pk(1,2,1,1), 4'd5, 1'b1);
        grade_it = 1'b1;
        master_pattern = pk(4,4,4,4);
        guess = pk(4,4,4,4);
        wait_n(1);
        grade_it = 1'b0;
        wait_n(10);

        issue(pk(3,3,3,3), pk(3,3,3,3), 4'd1, 1'b0);
        wait_n(5);
        clear = 1'b1;
        wait_n(1);
        clear = 1'b0;
        chk_zero("clear_in_color");
        wait_n(8);

        issue(pk(2,3,4,5), pk(2,3,4,5), 4'd1, 1'b1); wait_n(9);
        grade_it = 1'b1;
        clear = 1'b1;
        wait_n(1);
        grade_it = 1'b0;
        clear = 1'b0;
        chk_zero("clear_and_grade");
        wait_n(12);

        for (int t = 0; t < 40; t++) begin
            int          hi;
            logic [11:0] m, g;
            hi = $urandom_range(1, 7);
            m = pk($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
            g = pk($urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi), $urandom_range(0, hi));
            if ($urandom_range(0, 3) == 0) g = m;
            issue(m, g, 4'($urandom_range(0, 15)), 1'b1);
            if ($urandom_range(0, 1) == 0) wait_n(9);
            else wait_n(9 + $urandom_range(1, 3));
        end

        wait_n(12);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
